// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath blocks: divider state encoding and
// default operand/counter widths.
`timescale 1ns/1ps

package cpu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [2:0] DIV_IDLE   = 3'd0;
    localparam logic [2:0] DIV_LOAD   = 3'd1;
    localparam logic [2:0] DIV_RUN    = 3'd2;
    localparam logic [2:0] DIV_FINISH = 3'd3;
    localparam logic [2:0] DIV_DONE   = 3'd4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder and subtract the divisor when it fits.
`timescale 1ns/1ps

module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o,
    output logic             q_bit_o
);

    // The extra top bit keeps the compare exact even for a 2^(WIDTH-1) divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_i, dvd_i[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - dsr_i;
        q_bit_o = (shifted >= {1'b0, dsr_i});
        rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];
        dvd_o   = {dvd_i[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: quotient on LO, remainder on HI (sign of dividend),
// single-cycle divStop on completion or divZero for a zero divisor.
`timescale 1ns/1ps

module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DIV_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             divStop,
    output logic             divZero,
    output logic             div_busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             stop_q, stop_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .dvd_i   (dvd_q),
        .dsr_i   (dsr_q),
        .rem_o   (step_rem),
        .dvd_o   (step_dvd),
        .q_bit_o (step_q)
    );

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stop_d    = 1'b0;
        zero_d    = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (DIV_control) begin
                    dvd_d     = A;
                    dsr_d     = B;
                    neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
                    neg_rem_d = A[WIDTH-1];
                    state_d   = DIV_LOAD;
                end
            end
            DIV_LOAD: begin
                if (dsr_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = DIV_IDLE;
                end else begin
                    // The dividend sign was captured as neg_rem; the divisor is still raw here.
                    dvd_d   = neg_rem_q ? -dvd_q : dvd_q;
                    dsr_d   = dsr_q[WIDTH-1] ? -dsr_q : dsr_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                dvd_d = step_dvd | {{(WIDTH-1){1'b0}}, step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_FINISH;
                end
            end
            DIV_FINISH: begin
                lo_d    = neg_quo_q ? -dvd_q : dvd_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                stop_d  = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            stop_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            stop_q    <= stop_d;
            zero_q    <= zero_d;
        end
    end

    assign divStop  = stop_q;
    assign divZero  = zero_q;
    assign div_busy = (state_q != DIV_IDLE);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a result scoreboard,
// plus hand sequences for latency, divide-by-zero, mid-run reset and ignored starts.
`timescale 1ns/1ps

module tb_div_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        DIV_control;
    logic [31:0] A;
    logic [31:0] B;
    logic        divStop;
    logic        divZero;
    logic        div_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int stop_cnt = 0;
    int zero_cnt = 0;
    int busy_cnt = 0;

    exp_t sb_q[$];
    vec_t vecs[11];

    div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .DIV_control (DIV_control),
        .A           (A),
        .B           (B),
        .divStop     (divStop),
        .divZero     (divZero),
        .div_busy    (div_busy),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        stop_cnt <= stop_cnt + int'(divStop);
        zero_cnt <= zero_cnt + int'(divZero);
        busy_cnt <= busy_cnt + int'(div_busy);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit push);
        @(negedge clk);
        A = a;
        B = b;
        DIV_control = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        DIV_control = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_result(input string name, output int cycles);
        bit   found;
        exp_t e;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (divStop || divZero) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no divStop/divZero expected a result pulse", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got a result pulse expected none", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_stop"}, {31'd0, divStop}, {31'd0, ~e.zero});
            check({name, "_zero"}, {31'd0, divZero}, {31'd0, e.zero});
            check({name, "_lo"}, LO, e.lo);
            check({name, "_hi"}, HI, e.hi);
        end
        $display("op %s: LO=%h HI=%h after %0d cycles", name, LO, HI, cycles);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (div_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, div_busy}, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   s0;
        int   z0;
        int   b0;
        exp_t e;

        vecs[0]  = '{32'd100,       32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[5]  = '{32'd0,         32'd3,          32'd0,          32'd0};
        vecs[6]  = '{32'd7,         32'd100,        32'd0,          32'd7};
        vecs[7]  = '{32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[8]  = '{32'h7FFFFFFF,  32'h80000000,   32'd0,          32'h7FFFFFFF};
        vecs[9]  = '{32'h80000000,  32'h80000000,   32'd1,          32'd0};
        vecs[10] = '{32'd12345678,  32'd1000,       32'd12345,      32'd678};

        reset = 1'b1;
        DIV_control = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        check("rst_lo", LO, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_flags", {29'd0, divStop, divZero, div_busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, div_busy}, 32'd0);

        // Latency and busy duration for the reference operation.
        s0 = stop_cnt;
        b0 = busy_cnt;
        e = '{32'd14, 32'd2, 1'b0};
        start_op(32'd100, 32'd7, e, 1'b1);
        wait_result("lat_100_7", cyc);
        check("lat_cycles", cyc, 32'd35);
        wait_idle("lat");
        check("lat_busy_cycles", busy_cnt - b0, 32'd35);
        check("lat_stop_count", stop_cnt - s0, 32'd1);

        for (int i = 0; i < 11; i++) begin
            e = '{vecs[i].lo, vecs[i].hi, 1'b0};
            start_op(vecs[i].a, vecs[i].b, e, 1'b1);
            wait_result($sformatf("vec%0d", i), cyc);
            wait_idle($sformatf("vec%0d", i));
        end

        // Divide by zero leaves HI/LO alone and never signals completion.
        e = '{32'd14, 32'd2, 1'b0};
        start_op(32'd100, 32'd7, e, 1'b1);
        wait_result("pre_zero", cyc);
        wait_idle("pre_zero");
        s0 = stop_cnt;
        z0 = zero_cnt;
        e = '{32'd14, 32'd2, 1'b1};
        start_op(32'd5, 32'd0, e, 1'b1);
        wait_result("div0", cyc);
        check("div0_cycles", cyc, 32'd2);
        check("div0_busy", {31'd0, div_busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("div0_zero_count", zero_cnt - z0, 32'd1);
        check("div0_stop_count", stop_cnt - s0, 32'd0);
        check("div0_lo_kept", LO, 32'd14);
        check("div0_hi_kept", HI, 32'd2);

        // Asynchronous reset in the middle of RUN aborts the operation.
        s0 = stop_cnt;
        start_op(32'd100, 32'd7, e, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_lo", LO, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_flags", {29'd0, divStop, divZero, div_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_stop_count", stop_cnt - s0, 32'd0);
        check("midrst_busy", {31'd0, div_busy}, 32'd0);

        e = '{32'd4, 32'd1, 1'b0};
        start_op(32'd9, 32'd2, e, 1'b1);
        wait_result("after_rst_9_2", cyc);
        wait_idle("after_rst");

        // A second start request during RUN is dropped.
        s0 = stop_cnt;
        e = '{32'd6, 32'd2, 1'b0};
        start_op(32'd20, 32'd3, e, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        DIV_control = 1'b1;
        A = 32'd1;
        B = 32'd1;
        @(posedge clk);
        #1;
        DIV_control = 1'b0;
        wait_result("ignored_start", cyc);
        wait_idle("ignored_start");
        repeat (40) @(negedge clk);
        check("ignored_stop_count", stop_cnt - s0, 32'd1);
        check("ignored_lo", LO, 32'd6);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
